// File: rtl/entropy_src_ack_arb_sm_pkg.sv
// Shared types and constants for the entropy source ack arbiter FSM.
// The state encodings keep a Hamming distance of at least 3 so that a
// single flipped state bit never lands on another legal state.
package entropy_src_ack_arb_sm_pkg;

    localparam int StateWidth = 6;

    typedef enum logic [StateWidth-1:0] {
        StIdle     = 6'b011101,
        StWaitData = 6'b100110,
        StError    = 6'b111000
    } state_e;

    // Index width for a channel count, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/entropy_src_ack_rr_arb.sv
// Round-robin search: picks the requesting channel closest to ptr_i when
// counting upward with wrap-around. Purely combinational.
module entropy_src_ack_rr_arb #(
    parameter int NumChan = 2,
    parameter int IdxW    = 1
) (
    input  logic [NumChan-1:0] req_i,
    input  logic [IdxW-1:0]    ptr_i,
    output logic [IdxW-1:0]    winner_o,
    output logic               valid_o
);

    int off;
    int best_off;

    // Smallest forward distance from the pointer among set requests wins.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        off      = 0;
        best_off = NumChan;
        for (int j = 0; j < NumChan; j++) begin
            off = j - int'(ptr_i);
            if (off < 0) begin
                off = off + NumChan;
            end
            if (req_i[j] && (off < best_off)) begin
                best_off = off;
                winner_o = IdxW'(j);
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/entropy_src_ack_arb_sm.sv
// Req/ack arbiter handing FIFO words to NumChan consumers, one word per
// grant. Optional Wait_Data timeout is built when ENTROPY_SRC_ACK_TIMEOUT_EN
// is defined; otherwise Wait_Data waits indefinitely and timeout_o is 0.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// StIdle     | no grant outstanding; picks round-robin winner on request
// StWaitData | grant latched; acks when the FIFO has data
// StError    | terminal after escalation or illegal encoding, until reset
module entropy_src_ack_arb_sm
    import entropy_src_ack_arb_sm_pkg::*;
#(
    parameter int NumChan       = 2,
    parameter int DataW         = 32,
    parameter int TimeoutCycles = 256
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           enable_i,
    input  logic [NumChan-1:0]             req_i,
    output logic [NumChan-1:0]             ack_o,
    input  logic                           fifo_not_empty_i,
    input  logic [DataW-1:0]               fifo_rdata_i,
    output logic                           fifo_pop_o,
    output logic [DataW-1:0]               data_o,
    output logic [idx_width(NumChan)-1:0]  gnt_idx_o,
    output logic                           timeout_o,
    input  logic                           local_escalate_i,
    output logic                           ack_sm_err_o
);

    localparam int IdxW = idx_width(NumChan);
    localparam logic [NumChan-1:0] Chan0 = NumChan'(1);

    // Raw vector rather than the enum so any corrupted value stays visible
    // to the decode below and lands in the default arm.
    logic [StateWidth-1:0] state_q;
    state_e                state_d;
    logic [IdxW-1:0]       ptr_q, ptr_d;
    logic [IdxW-1:0]       gnt_q, gnt_d;
    logic [IdxW-1:0]       win_idx;
    logic                  win_valid;
    logic [NumChan-1:0]    gnt_mask;
    logic                  gnt_req;
    logic                  ack;
    logic                  to_hit;

    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] i);
        return (i == IdxW'(NumChan - 1)) ? '0 : i + 1'b1;
    endfunction

    entropy_src_ack_rr_arb #(
        .NumChan (NumChan),
        .IdxW    (IdxW)
    ) u_rr_arb (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .winner_o (win_idx),
        .valid_o  (win_valid)
    );

    assign gnt_mask = Chan0 << gnt_q;
    assign gnt_req  = |(req_i & gnt_mask);

`ifdef ENTROPY_SRC_ACK_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles);
    logic [CntW-1:0] cnt_q, cnt_d;

    assign to_hit = (cnt_q == CntW'(TimeoutCycles - 1));

    // Held at zero in Idle so every Wait_Data entry starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle) begin
            cnt_d = '0;
        end else if ((state_q == StWaitData) && !ack) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Wait_Data dwell counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    // Next-state, grant/pointer update and per-state strobes.
    always_comb begin
        state_d      = StError;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        ack          = 1'b0;
        timeout_o    = 1'b0;
        ack_sm_err_o = 1'b0;
        case (state_q)
            StIdle: begin
                state_d = StIdle;
                if (enable_i && win_valid) begin
                    gnt_d   = win_idx;
                    state_d = StWaitData;
                end
            end
            StWaitData: begin
                state_d = StWaitData;
                if (!enable_i || !gnt_req) begin
                    state_d = StIdle;
                end else if (fifo_not_empty_i) begin
                    ack     = 1'b1;
                    ptr_d   = next_idx(gnt_q);
                    state_d = StIdle;
                end else if (to_hit) begin
                    timeout_o = 1'b1;
                    ptr_d     = next_idx(gnt_q);
                    state_d   = StIdle;
                end
            end
            StError: begin
                ack_sm_err_o = 1'b1;
            end
            default: begin
                ack_sm_err_o = 1'b1;
            end
        endcase
        // Escalation only redirects the next state; this cycle's strobes stand.
        if (local_escalate_i) begin
            state_d = StError;
        end
    end

    assign ack_o      = ack ? gnt_mask : '0;
    assign fifo_pop_o = ack;
    assign data_o     = ack ? fifo_rdata_i : '0;
    assign gnt_idx_o  = gnt_q;

    // Sparse state flops plus round-robin pointer and latched grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
        end
    end

endmodule

// File: tb/tb_entropy_src_ack_arb_sm.sv
// Scoreboard bench for entropy_src_ack_arb_sm (NumChan=4, TimeoutCycles=8).
// Expectations follow ENTROPY_SRC_ACK_TIMEOUT_EN when it is defined.
module tb_entropy_src_ack_arb_sm;
    import entropy_src_ack_arb_sm_pkg::*;

    localparam int NumChan       = 4;
    localparam int DataW         = 32;
    localparam int TimeoutCycles = 8;
`ifdef ENTROPY_SRC_ACK_TIMEOUT_EN
    localparam int EmptyWait = 5;
`else
    localparam int EmptyWait = 10;
`endif

    logic               clk_i;
    logic               rst_ni;
    logic               enable_i;
    logic [NumChan-1:0] req_i;
    logic [NumChan-1:0] ack_o;
    logic               fifo_not_empty_i;
    logic [DataW-1:0]   fifo_rdata_i;
    logic               fifo_pop_o;
    logic [DataW-1:0]   data_o;
    logic [1:0]         gnt_idx_o;
    logic               timeout_o;
    logic               local_escalate_i;
    logic               ack_sm_err_o;

    typedef struct {
        logic        is_to;
        logic [3:0]  ack;
        logic [31:0] data;
        logic [1:0]  gnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    bit   exp_err = 1'b0;

    entropy_src_ack_arb_sm #(
        .NumChan       (NumChan),
        .DataW         (DataW),
        .TimeoutCycles (TimeoutCycles)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .enable_i         (enable_i),
        .req_i            (req_i),
        .ack_o            (ack_o),
        .fifo_not_empty_i (fifo_not_empty_i),
        .fifo_rdata_i     (fifo_rdata_i),
        .fifo_pop_o       (fifo_pop_o),
        .data_o           (data_o),
        .gnt_idx_o        (gnt_idx_o),
        .timeout_o        (timeout_o),
        .local_escalate_i (local_escalate_i),
        .ack_sm_err_o     (ack_sm_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic is_to, input logic [3:0] a, input logic [31:0] d,
                        input logic [1:0] g);
        exp_t e;
        e.is_to = is_to;
        e.ack   = a;
        e.data  = d;
        e.gnt   = g;
        exp_q.push_back(e);
    endtask

    // One request/ack handshake with the FIFO already holding data.
    task automatic xact(input logic [3:0] r, input logic [31:0] d, input logic [3:0] a,
                        input logic [1:0] g);
        req_i            = r;
        fifo_rdata_i     = d;
        fifo_not_empty_i = 1'b1;
        push(1'b0, a, d, g);
        cyc(2);
    endtask

    // Monitor: pops an expectation whenever the DUT strobes ack, pop or timeout.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if ((ack_o != '0) || fifo_pop_o || timeout_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: ack=%b pop=%b timeout=%b with nothing expected",
                             ack_o, fifo_pop_o, timeout_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ack", 64'(ack_o), 64'(mon_e.ack));
                    chk("pop", 64'(fifo_pop_o), 64'(mon_e.ack != '0));
                    chk("data", 64'(data_o), 64'(mon_e.data));
                    chk("timeout", 64'(timeout_o), 64'(mon_e.is_to));
                    chk("gnt_idx", 64'(gnt_idx_o), 64'(mon_e.gnt));
                end
            end else begin
                chk("data_zero", 64'(data_o), 64'd0);
            end
            chk("sm_err", 64'(ack_sm_err_o), 64'(exp_err));
        end
    end

    initial begin
        rst_ni           = 1'b0;
        enable_i         = 1'b0;
        req_i            = '0;
        fifo_not_empty_i = 1'b0;
        fifo_rdata_i     = '0;
        local_escalate_i = 1'b0;
        cyc(2);
        chk("rst_ack", 64'(ack_o), 64'd0);
        chk("rst_pop", 64'(fifo_pop_o), 64'd0);
        chk("rst_data", 64'(data_o), 64'd0);
        chk("rst_gnt", 64'(gnt_idx_o), 64'd0);
        chk("rst_timeout", 64'(timeout_o), 64'd0);
        chk("rst_err", 64'(ack_sm_err_o), 64'd0);
        chk("rst_state", 64'(dut.state_q), 64'(StIdle));
        rst_ni   = 1'b1;
        enable_i = 1'b1;

        // Round-robin order and wrap-around.
        xact(4'b1010, 32'h0000_00A1, 4'b0010, 2'd1);
        xact(4'b1010, 32'h0000_00A2, 4'b1000, 2'd3);
        xact(4'b0101, 32'h0000_00A3, 4'b0001, 2'd0);
        xact(4'b0101, 32'h0000_00A4, 4'b0100, 2'd2);
        xact(4'b0101, 32'h0000_00A5, 4'b0001, 2'd0);
        req_i            = '0;
        fifo_not_empty_i = 1'b0;
        cyc(1);

        // Ack held off by an empty FIFO, delivered on the first non-empty cycle.
        req_i = 4'b0001;
        cyc(EmptyWait);
        fifo_rdata_i     = 32'hDEADBEEF;
        fifo_not_empty_i = 1'b1;
        push(1'b0, 4'b0001, 32'hDEADBEEF, 2'd0);
        cyc(1);
        req_i            = '0;
        fifo_not_empty_i = 1'b0;
        cyc(1);

        // Starved channel 2: timeout and pointer advance, or indefinite wait.
        req_i = 4'b0100;
`ifdef ENTROPY_SRC_ACK_TIMEOUT_EN
        push(1'b1, 4'b0000, 32'h0, 2'd2);
        cyc(9);
        req_i            = 4'b1010;
        fifo_rdata_i     = 32'h0000_00C3;
        fifo_not_empty_i = 1'b1;
        push(1'b0, 4'b1000, 32'h0000_00C3, 2'd3);
        cyc(2);
`else
        cyc(12);
        req_i = '0;
        cyc(1);
        req_i            = 4'b1010;
        fifo_rdata_i     = 32'h0000_00C3;
        fifo_not_empty_i = 1'b1;
        push(1'b0, 4'b0010, 32'h0000_00C3, 2'd1);
        cyc(2);
`endif
        req_i            = '0;
        fifo_not_empty_i = 1'b0;
        cyc(1);

        // enable_i dropped in Wait_Data with data present: no ack, pointer kept.
        req_i = 4'b0001;
        cyc(2);
        enable_i         = 1'b0;
        fifo_not_empty_i = 1'b1;
        fifo_rdata_i     = 32'h0000_0BAD;
        cyc(1);
        chk("en_drop_state", 64'(dut.state_q), 64'(StIdle));
        enable_i = 1'b1;
        xact(4'b0011, 32'h0000_00C4, 4'b0001, 2'd0);
        req_i            = '0;
        fifo_not_empty_i = 1'b0;
        cyc(1);

        // Granted request withdrawn in Wait_Data: no ack, pointer kept.
        req_i = 4'b0100;
        cyc(2);
        req_i            = '0;
        fifo_not_empty_i = 1'b1;
        cyc(1);
        chk("req_drop_state", 64'(dut.state_q), 64'(StIdle));
        xact(4'b1100, 32'h0000_00C5, 4'b0100, 2'd2);
        req_i            = '0;
        fifo_not_empty_i = 1'b0;
        cyc(1);

        // Escalation alongside a would-be ack: ack still seen, then Error.
        req_i = 4'b0001;
        cyc(1);
        fifo_not_empty_i = 1'b1;
        fifo_rdata_i     = 32'h0000_00E5;
        local_escalate_i = 1'b1;
        push(1'b0, 4'b0001, 32'h0000_00E5, 2'd0);
        cyc(1);
        local_escalate_i = 1'b0;
        exp_err          = 1'b1;
        chk("esc_state", 64'(dut.state_q), 64'(StError));
        req_i = 4'b1111;
        cyc(5);
        chk("esc_err_held", 64'(ack_sm_err_o), 64'd1);

        // Reset clears Error.
        rst_ni           = 1'b0;
        exp_err          = 1'b0;
        req_i            = '0;
        fifo_not_empty_i = 1'b0;
        #1;
        chk("rst2_err", 64'(ack_sm_err_o), 64'd0);
        cyc(1);
        rst_ni = 1'b1;
        cyc(1);

        // Reset in the middle of Wait_Data abandons the transaction.
        req_i = 4'b0010;
        cyc(2);
        fifo_rdata_i     = 32'h0000_00F0;
        fifo_not_empty_i = 1'b1;
        rst_ni           = 1'b0;
        #1;
        chk("rst_mid_ack", 64'(ack_o), 64'd0);
        chk("rst_mid_pop", 64'(fifo_pop_o), 64'd0);
        cyc(1);
        req_i  = '0;
        rst_ni = 1'b1;
        chk("rst_mid_gnt", 64'(gnt_idx_o), 64'd0);
        chk("rst_mid_state", 64'(dut.state_q), 64'(StIdle));
        cyc(1);
        xact(4'b0011, 32'h0000_00F1, 4'b0001, 2'd0);
        req_i            = '0;
        fifo_not_empty_i = 1'b0;
        cyc(1);

        // Illegal encoding: error flag immediately, Error state next cycle.
        force dut.state_q = 6'b000000;
        exp_err = 1'b1;
        #1;
        chk("illegal_err", 64'(ack_sm_err_o), 64'd1);
        chk("illegal_ack", 64'(ack_o), 64'd0);
        @(negedge clk_i);
        #1;
        release dut.state_q;
        cyc(1);
        chk("illegal_to_error", 64'(dut.state_q), 64'(StError));
        cyc(2);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
